// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
//   Self-contained UART transmit serialiser with its own baud divider.
//   It accepts one byte over a valid/ready handshake and sends one frame:
//   a start bit, DATA_BITS data bits LSB first, an optional parity bit,
//   and STOP_BITS stop bits. Each bit lasts DIV clock cycles.
//
// Ports
//   CLOCK_50  in   sole clock, rising edge
//   reset_n   in   synchronous reset, active-low
//   tx_data   in   payload, captured on accept (tx_valid & tx_ready)
//   tx_valid  in   source has data; the source holds it until accepted
//   tx_ready  out  high only in IDLE
//   tx        out  serial line, idle high, registered
//   busy      out  high from accept until the last stop bit ends
//   load      out  one-cycle pulse in the LOAD state
//   enable    out  one-cycle pulse on the last cycle of every bit period
// ---------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DIV        = (CLK_HZ + BAUD / 2) / BAUD,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 CLOCK_50,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 load,
    output logic                 enable
);

    // Parameter sanity: refuse to elaborate an unusable configuration.
    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_frame: DIV must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W  = 4;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  tx_ready_q, busy_q, load_q, enable_q;
    logic                  active_q, active_d, bit_end;
    logic [DATA_BITS-1:0]  shifted;

    // Next-state, counters and capture.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        bit_d    = bit_q;
        data_d   = data_q;
        parity_d = parity_q;

        active_q = state_q inside {START, DATA, PARITY, STOP};
        bit_end  = active_q && (baud_q == BAUD_LAST);
        // The divider only runs while a bit is on the line, so it is
        // already zero on entry to START.
        baud_d   = (active_q && !bit_end) ? baud_q + 1'b1 : '0;

        case (state_q)
            IDLE: begin
                bit_d = '0;
                if (tx_valid) begin
                    data_d   = tx_data;
                    parity_d = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
                    state_d  = LOAD;
                end
            end
            LOAD: state_d = START;
            START: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                bit_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state and registered, so each
    // output changes on the same edge as the state it belongs to.
    always_comb begin
        shifted  = data_q >> bit_d;
        active_d = state_d inside {START, DATA, PARITY, STOP};
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shifted[0];
            PARITY:  tx_d = parity_q;
            default: tx_d = 1'b1;
        endcase
    end

    // NOTE: reset is sampled inside the clocked block only (synchronous),
    // and all state uses non-blocking assignments so every register sees
    // the pre-edge values of the others.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            data_q     <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            load_q     <= 1'b0;
            enable_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            tx_ready_q <= (state_d == IDLE);
            busy_q     <= (state_d != IDLE);
            load_q     <= (state_d == LOAD);
            enable_q   <= active_d && (baud_d == BAUD_LAST);
        end
    end

    assign tx       = tx_q;
    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign load     = load_q;
    assign enable   = enable_q;

endmodule
